gate_test_sequencer: RTL and testbench

GATE_TEST_SEQUENCER -- requirements
Module: gate_test_sequencer

---
 rtl/gate_test_sequencer_if.sv | 24 ++
 rtl/gate_test_sequencer.sv | 125 ++++++++++++
 tb/tb_gate_test_sequencer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/gate_test_sequencer_if.sv
// rtl/gate_test_sequencer_if.sv - control, datapath-drive and result signals of the gate test sequencer
interface gate_test_sequencer_if;
  logic       start;
  logic       abort;
  logic [3:0] s_in;
  logic       a_out;
  logic       b_out;
  logic       c_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] fail_count;
  logic [2:0] first_fail;

  modport master (
    output start, abort, s_in,
    input  a_out, b_out, c_out, busy, done, pass, fail_count, first_fail
  );

  modport slave (
    input  start, abort, s_in,
    output a_out, b_out, c_out, busy, done, pass, fail_count, first_fail
  );
endinterface

// File: rtl/gate_test_sequencer.sv
// rtl/gate_test_sequencer.sv - sweeps all 8 {A,B,C} vectors and compares the datapath against a truth table
module gate_test_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [31:0] EXPECTED      = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  gate_test_sequencer_if.slave  bus
);
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] fail_count_q, fail_count_d;
  logic [2:0] first_fail_q, first_fail_d;
  logic       pass_q, pass_d;

  logic       running;
  logic [3:0] exp_nibble;
  logic       mismatch;

  assign running    = (state_q == ST_DRIVE) || (state_q == ST_SETTLE) || (state_q == ST_CHECK);
  assign exp_nibble = EXPECTED[{idx_q, 2'b00} +: 4];
  assign mismatch   = (bus.s_in != exp_nibble);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= 3'd0;
      cnt_q        <= 4'd0;
      fail_count_q <= 4'd0;
      first_fail_q <= 3'd0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      fail_count_q <= fail_count_d;
      first_fail_q <= first_fail_d;
      pass_q       <= pass_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    fail_count_d = fail_count_q;
    first_fail_d = first_fail_q;
    pass_d       = pass_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          idx_d        = 3'd0;
          fail_count_d = 4'd0;
          first_fail_d = 3'd0;
          pass_d       = 1'b0;
          state_d      = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        cnt_d   = SETTLE_LOAD;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q <= 4'd1) begin
          state_d = ST_CHECK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_CHECK: begin
        if (mismatch) begin
          fail_count_d = fail_count_q + 4'd1;
          if (fail_count_q == 4'd0) begin
            first_fail_d = idx_q;
          end
        end
        // idx stops at 7 so the sweep can never wrap back onto vector 0
        if (idx_q == 3'd7) begin
          pass_d  = (fail_count_d == 4'd0);
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = ST_DRIVE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // abort wins over any CHECK update in the same cycle; results freeze as they were
    if (running && bus.abort) begin
      state_d      = ST_IDLE;
      idx_d        = idx_q;
      cnt_d        = cnt_q;
      fail_count_d = fail_count_q;
      first_fail_d = first_fail_q;
      pass_d       = pass_q;
    end
  end

  assign bus.a_out      = idx_q[2];
  assign bus.b_out      = idx_q[1];
  assign bus.c_out      = idx_q[0];
  assign bus.busy       = running;
  assign bus.done       = (state_q == ST_DONE);
  assign bus.pass       = pass_q;
  assign bus.fail_count = fail_count_q;
  assign bus.first_fail = first_fail_q;
endmodule

// File: tb/tb_gate_test_sequencer.sv
// tb/tb_gate_test_sequencer.sv - randomized and directed checks of gate_test_sequencer against a truth-table model
module tb_gate_test_sequencer;
  localparam logic [31:0] EXP_WORD = 32'h7326_E8AC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gate_test_sequencer_if ifa ();
  gate_test_sequencer_if ifb ();

  logic [3:0] and_mask [2];
  logic [3:0] xmask_a [8];
  logic [3:0] xmask_b [8];

  int checks   = 0;
  int failures = 0;

  function automatic logic [3:0] golden(input logic [2:0] v);
    logic a, b, c;
    a = v[2]; b = v[1]; c = v[0];
    return {~a, ~(b ^ c), a | c, a & b};
  endfunction

  assign ifa.s_in = (golden({ifa.a_out, ifa.b_out, ifa.c_out}) & and_mask[0]) ^ xmask_a[{ifa.a_out, ifa.b_out, ifa.c_out}];
  assign ifb.s_in = (golden({ifb.a_out, ifb.b_out, ifb.c_out}) & and_mask[1]) ^ xmask_b[{ifb.a_out, ifb.b_out, ifb.c_out}];

  gate_test_sequencer #(.SETTLE_CYCLES(2), .EXPECTED(EXP_WORD)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  gate_test_sequencer #(.SETTLE_CYCLES(1), .EXPECTED(EXP_WORD)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input int inst, input logic v);
    if (inst == 0) ifa.start = v; else ifb.start = v;
  endtask

  task automatic set_abort(input int inst, input logic v);
    if (inst == 0) ifa.abort = v; else ifb.abort = v;
  endtask

  task automatic get_obs(input int inst, output logic [2:0] abc, output logic busy, output logic done,
                         output logic pass, output logic [3:0] fc, output logic [2:0] ff);
    if (inst == 0) begin
      abc = {ifa.a_out, ifa.b_out, ifa.c_out}; busy = ifa.busy; done = ifa.done;
      pass = ifa.pass; fc = ifa.fail_count; ff = ifa.first_fail;
    end else begin
      abc = {ifb.a_out, ifb.b_out, ifb.c_out}; busy = ifb.busy; done = ifb.done;
      pass = ifb.pass; fc = ifb.fail_count; ff = ifb.first_fail;
    end
  endtask

  // Reference: result of comparing the first nvec vectors of the attached datapath against the table
  task automatic model(input int inst, input int nvec, output int efc, output int eff, output bit epass);
    logic [31:0] ew;
    logic [3:0]  got;
    ew = EXP_WORD; efc = 0; eff = 0;
    for (int v = 0; v < nvec; v++) begin
      got = (golden(3'(v)) & and_mask[inst]) ^ ((inst == 0) ? xmask_a[v] : xmask_b[v]);
      if (got != ew[4*v +: 4]) begin
        if (efc == 0) eff = v;
        efc++;
      end
    end
    epass = (efc == 0);
  endtask

  // Full sweep: every cycle from the start edge to DONE is checked against timing arithmetic
  task automatic run_sweep(input int inst, input int s, input bit hold, input string tag);
    int efc, eff, n;
    bit epass;
    logic [2:0] abc; logic busy, done, pass; logic [3:0] fc; logic [2:0] ff;
    model(inst, 8, efc, eff, epass);
    n = 8 * (s + 2);
    @(negedge clk);
    get_obs(inst, abc, busy, done, pass, fc, ff);
    chk({tag, "_idle_before"}, {31'd0, busy}, 0);
    set_start(inst, 1'b1);
    @(posedge clk);
    for (int t = 0; t <= n; t++) begin
      @(negedge clk);
      if (!hold && t == 0) set_start(inst, 1'b0);
      get_obs(inst, abc, busy, done, pass, fc, ff);
      if (t < n) begin
        chk({tag, "_abc"}, {29'd0, abc}, t / (s + 2));
        chk({tag, "_busy"}, {31'd0, busy}, 1);
        chk({tag, "_done_low"}, {31'd0, done}, 0);
        chk({tag, "_pass_low"}, {31'd0, pass}, 0);
      end else begin
        chk({tag, "_done"}, {31'd0, done}, 1);
        chk({tag, "_busy_done"}, {31'd0, busy}, 0);
        chk({tag, "_abc_last"}, {29'd0, abc}, 7);
        chk({tag, "_pass"}, {31'd0, pass}, epass);
        chk({tag, "_fail_count"}, {28'd0, fc}, efc);
        chk({tag, "_first_fail"}, {29'd0, ff}, eff);
      end
    end
  endtask

  initial begin
    logic [2:0] abc; logic busy, done, pass; logic [3:0] fc; logic [2:0] ff;
    int efc, eff, done_seen, inst;
    bit epass;
    ifa.start = 0; ifa.abort = 0; ifb.start = 0; ifb.abort = 0;
    and_mask[0] = 4'hF; and_mask[1] = 4'hF;
    for (int v = 0; v < 8; v++) begin xmask_a[v] = 4'h0; xmask_b[v] = 4'h0; end

    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      get_obs(i, abc, busy, done, pass, fc, ff);
      chk("reset_outputs", {abc, busy, done, pass, fc, ff}, 0);
    end
    rst = 1'b0;

    run_sweep(0, 2, 1'b0, "golden");

    and_mask[0] = 4'b1101;
    run_sweep(0, 2, 1'b0, "s2_stuck");

    // abort in SETTLE (t=13) and in CHECK (t=15) of vector 3
    for (int k = 0; k < 2; k++) begin
      int tab;
      tab = (k == 0) ? 13 : 15;
      @(negedge clk);
      ifa.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ifa.start = 1'b0;
      repeat (tab) @(negedge clk);
      get_obs(0, abc, busy, done, pass, fc, ff);
      chk("abort_pre_abc", {29'd0, abc}, 3);
      ifa.abort = 1'b1;
      @(negedge clk);
      ifa.abort = 1'b0;
      model(0, 3, efc, eff, epass);
      get_obs(0, abc, busy, done, pass, fc, ff);
      chk("abort_busy", {31'd0, busy}, 0);
      chk("abort_pass", {31'd0, pass}, 0);
      chk("abort_abc", {29'd0, abc}, 3);
      chk("abort_fail_count", {28'd0, fc}, efc);
      chk("abort_first_fail", {29'd0, ff}, eff);
      done_seen = 0;
      repeat (40) begin
        @(negedge clk);
        if (ifa.done || ifa.busy) done_seen++;
      end
      chk("abort_no_done", done_seen, 0);
    end
    run_sweep(0, 2, 1'b0, "after_abort");

    // asynchronous reset mid-cycle at vector 5
    @(negedge clk);
    ifa.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ifa.start = 1'b0;
    repeat (22) @(negedge clk);
    get_obs(0, abc, busy, done, pass, fc, ff);
    chk("rst_pre_abc", {29'd0, abc}, 5);
    #1 rst = 1'b1;
    #1;
    get_obs(0, abc, busy, done, pass, fc, ff);
    chk("rst_async_outputs", {abc, busy, done, pass, fc, ff}, 0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (ifa.done || ifa.busy || ifa.a_out || ifa.b_out || ifa.c_out) done_seen++;
    end
    chk("rst_stays_idle", done_seen, 0);
    and_mask[0] = 4'hF;
    run_sweep(0, 2, 1'b0, "after_rst");

    // start held across a sweep and its DONE cycle: back-to-back sweeps
    run_sweep(1, 1, 1'b1, "held1");
    run_sweep(1, 1, 1'b0, "held2");

    // abort while idle changes nothing
    @(negedge clk);
    ifb.abort = 1'b1;
    repeat (3) @(negedge clk);
    ifb.abort = 1'b0;
    get_obs(1, abc, busy, done, pass, fc, ff);
    chk("idle_abort_state", {abc, busy, done, pass, fc, ff}, {3'd7, 1'b0, 1'b0, 1'b1, 4'd0, 3'd0});

    for (int r = 0; r < 6; r++) begin
      inst = int'($urandom_range(0, 1));
      for (int v = 0; v < 8; v++) begin
        logic [3:0] m;
        m = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
        if (inst == 0) xmask_a[v] = m; else xmask_b[v] = m;
      end
      run_sweep(inst, (inst == 0) ? 2 : 1, 1'b0, "random");
      for (int v = 0; v < 8; v++) begin xmask_a[v] = 4'h0; xmask_b[v] = 4'h0; end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
